// File: rtl/sum_scheduler_if.sv
// Request/result bundle between the vector-sum clients and the shared scheduler.
// The scheduler connects through the slave modport and clients through master.
interface sum_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 8,
  parameter int NUM_REQ    = 4
);
  localparam int SUM_WIDTH = DATA_WIDTH + $clog2(LENGTH);
  localparam int ID_WIDTH  = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                             req;
  logic [NUM_REQ-1:0][LENGTH-1:0][DATA_WIDTH-1:0] req_data;
  logic                                           flush;
  logic [NUM_REQ-1:0]                             ack;
  logic                                           busy;
  logic [SUM_WIDTH-1:0]                           result;
  logic [ID_WIDTH-1:0]                            result_id;
  logic                                           result_valid;
  logic                                           result_ready;

  modport master (
    output req, req_data, flush, result_ready,
    input  ack, busy, result, result_id, result_valid
  );

  modport slave (
    input  req, req_data, flush, result_ready,
    output ack, busy, result, result_id, result_valid
  );
endinterface

// File: rtl/sum_scheduler.sv
// Round-robin scheduler sharing one sequential accumulator among NUM_REQ clients.
// The winner's vector is snapshotted at grant and summed one element per cycle.
module sum_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 8,
  parameter int NUM_REQ    = 4
) (
  input logic            clk,
  input logic            rst,
  sum_scheduler_if.slave bus
);
  localparam int SUM_WIDTH = DATA_WIDTH + $clog2(LENGTH);
  localparam int ID_WIDTH  = $clog2(NUM_REQ);
  localparam int PTR_WIDTH = $clog2(LENGTH);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(LENGTH - 1);
  localparam logic [ID_WIDTH-1:0]  LAST_ID  = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                            state_r;
  state_t                            next_state_s;
  logic [LENGTH-1:0][DATA_WIDTH-1:0] data_buf_r;
  logic [SUM_WIDTH-1:0]              acc_r, acc_s, sum_s;
  logic [PTR_WIDTH-1:0]              ptr_r, ptr_s;
  logic [ID_WIDTH-1:0]               last_r, last_s;
  logic [ID_WIDTH-1:0]               cand_s, winner_s;
  logic                              found_s, load_s;
  logic [NUM_REQ-1:0]                ack_r, ack_s;
  logic                              busy_r, busy_s;
  logic                              result_valid_r, result_valid_s;
  logic [SUM_WIDTH-1:0]              result_r, result_s;
  logic [ID_WIDTH-1:0]               result_id_r, result_id_s;

  assign sum_s = acc_r + SUM_WIDTH'(data_buf_r[ptr_r]);

  // Round-robin search: first set request strictly after the last winner.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    cand_s   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = ID_WIDTH'((int'(last_r) + i) % NUM_REQ);
      if (!found_s && bus.req[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; flush outranks every other event.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.flush) begin
          next_state_s = IDLE;
        end else if (found_s) begin
          next_state_s = ACCUM;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCUM: begin
        if (bus.flush) begin
          next_state_s = IDLE;
        end else if (ptr_r == LAST_PTR) begin
          next_state_s = DONE;
        end else begin
          next_state_s = ACCUM;
        end
      end
      DONE: begin
        if (bus.flush || bus.result_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Next values for the registered outputs and the datapath.
  always_comb begin
    ack_s          = '0;
    busy_s         = busy_r;
    result_s       = result_r;
    result_valid_s = result_valid_r;
    result_id_s    = result_id_r;
    last_s         = last_r;
    acc_s          = acc_r;
    ptr_s          = ptr_r;
    load_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.flush) begin
          busy_s = 1'b0;
        end else if (found_s) begin
          ack_s       = NUM_REQ'(1'b1) << winner_s;
          busy_s      = 1'b1;
          result_id_s = winner_s;
          last_s      = winner_s;
          acc_s       = '0;
          ptr_s       = '0;
          load_s      = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      ACCUM: begin
        if (bus.flush) begin
          busy_s         = 1'b0;
          result_valid_s = 1'b0;
        end else begin
          acc_s = sum_s;
          ptr_s = ptr_r + PTR_WIDTH'(1'b1);
          if (ptr_r == LAST_PTR) begin
            result_s       = sum_s;
            result_valid_s = 1'b1;
          end else begin
            result_valid_s = 1'b0;
          end
        end
      end
      DONE: begin
        if (bus.flush || bus.result_ready) begin
          busy_s         = 1'b0;
          result_valid_s = 1'b0;
        end else begin
          busy_s         = 1'b1;
          result_valid_s = 1'b1;
        end
      end
      default: begin
        busy_s         = 1'b0;
        result_valid_s = 1'b0;
      end
    endcase
  end

  // Output, pointer and snapshot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r          <= '0;
      busy_r         <= 1'b0;
      result_r       <= '0;
      result_valid_r <= 1'b0;
      result_id_r    <= '0;
      last_r         <= LAST_ID;
      acc_r          <= '0;
      ptr_r          <= '0;
      data_buf_r     <= '0;
    end else begin
      ack_r          <= ack_s;
      busy_r         <= busy_s;
      result_r       <= result_s;
      result_valid_r <= result_valid_s;
      result_id_r    <= result_id_s;
      last_r         <= last_s;
      acc_r          <= acc_s;
      ptr_r          <= ptr_s;
      if (load_s) begin
        data_buf_r <= bus.req_data[winner_s];
      end else begin
        data_buf_r <= data_buf_r;
      end
    end
  end

  assign bus.ack          = ack_r;
  assign bus.busy         = busy_r;
  assign bus.result       = result_r;
  assign bus.result_id    = result_id_r;
  assign bus.result_valid = result_valid_r;
endmodule

// File: tb/tb_sum_scheduler.sv
// Self-checking bench for sum_scheduler: directed scenarios plus randomized jobs
// checked against a transaction-level round-robin / vector-sum model.
module tb_sum_scheduler;
  localparam int DW = 32;
  localparam int LEN = 8;
  localparam int NR = 4;
  localparam int SW = DW + $clog2(LEN);
  localparam int IW = $clog2(NR);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_last;

  sum_scheduler_if #(.DATA_WIDTH(DW), .LENGTH(LEN), .NUM_REQ(NR)) bus ();

  sum_scheduler #(.DATA_WIDTH(DW), .LENGTH(LEN), .NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: next winner after 'last', wrapping.
  function automatic int rr_pick(input logic [NR-1:0] r, input int last);
    int idx;
    for (int i = 1; i <= NR; i++) begin
      idx = (last + i) % NR;
      if (r[idx[IW-1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [SW-1:0] vec_sum(input logic [LEN-1:0][DW-1:0] v);
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < LEN; i++) s = s + SW'(v[i]);
    return s;
  endfunction

  function automatic logic [NR-1:0] onehot(input int w);
    logic [NR-1:0] o;
    o = '0;
    if (w >= 0) o[w[IW-1:0]] = 1'b1;
    return o;
  endfunction

  task automatic rand_vec(input int r);
    for (int i = 0; i < LEN; i++) bus.req_data[r][i] = $urandom();
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.flush = 1'b0;
    bus.result_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_last = NR - 1;
  endtask

  task automatic wait_ack(input int budget, output logic [NR-1:0] a, output int n);
    a = '0;
    n = 0;
    while (a == '0 && n < budget) begin
      @(negedge clk);
      n++;
      a = bus.ack;
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (bus.result_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ack=%b busy=%b valid=%b, want 0000/0/0", bus.ack, bus.busy, bus.result_valid);
    end
    checks++;
    if (bus.result !== 35'd0 || bus.result_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_data: result=%h id=%0d, want 0/0", bus.result, bus.result_id);
    end
  endtask

  task automatic test_single();
    logic [NR-1:0] a;
    int n;
    do_reset();
    for (int i = 0; i < LEN; i++) bus.req_data[0][i] = DW'(i + 1);
    bus.req = 4'b0001;
    wait_ack(4, a, n);
    checks++;
    if (a !== 4'b0001 || n != 1) begin
      errors++;
      $display("FAIL single_ack: ack=%b after %0d cycles, want 0001 after 1", a, n);
    end
    bus.req = '0;
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_ack_pulse: ack=%b, want 0000", bus.ack);
    end
    wait_valid(20, n);
    checks++;
    if (n + 1 != LEN || bus.result !== 35'd36 || bus.result_id !== 2'd0) begin
      errors++;
      $display("FAIL single_result: latency=%0d result=%0d id=%0d, want 8/36/0", n + 1, bus.result, bus.result_id);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: busy=%b valid=%b, want 0/0", bus.busy, bus.result_valid);
    end
  endtask

  task automatic test_all_req();
    logic [NR-1:0] a;
    logic [SW-1:0] exp_sum;
    int n, exp_w, prev_t;
    do_reset();
    for (int r = 0; r < NR; r++) rand_vec(r);
    bus.req = 4'b1111;
    prev_t = 0;
    for (int j = 0; j < NR; j++) begin
      exp_w = rr_pick(bus.req, model_last);
      wait_ack(30, a, n);
      checks++;
      if (a !== onehot(exp_w) || (j > 0 && cyc - prev_t != LEN + 2)) begin
        errors++;
        $display("FAIL all_ack_%0d: ack=%b spacing=%0d, want %b spacing %0d", j, a, cyc - prev_t, onehot(exp_w), LEN + 2);
      end
      prev_t = cyc;
      exp_sum = vec_sum(bus.req_data[exp_w]);
      model_last = exp_w;
      bus.req[exp_w] = 1'b0;
      rand_vec(exp_w);
      wait_valid(20, n);
      checks++;
      if (n != LEN || bus.result !== exp_sum || bus.result_id !== IW'(exp_w)) begin
        errors++;
        $display("FAIL all_result_%0d: latency=%0d result=%h id=%0d, want %0d/%h/%0d", j, n, bus.result, bus.result_id, LEN, exp_sum, exp_w);
      end
    end
  endtask

  task automatic test_fairness();
    logic [NR-1:0] a;
    logic [SW-1:0] exp_sum;
    int n, exp_w;
    do_reset();
    for (int r = 0; r < NR; r++) rand_vec(r);
    bus.req = 4'b0101;
    for (int j = 0; j < 4; j++) begin
      exp_w = rr_pick(bus.req, model_last);
      wait_ack(30, a, n);
      checks++;
      if (a !== onehot(exp_w)) begin
        errors++;
        $display("FAIL fair_ack_%0d: ack=%b, want %b", j, a, onehot(exp_w));
      end
      exp_sum = vec_sum(bus.req_data[exp_w]);
      model_last = exp_w;
      rand_vec(exp_w);
      wait_valid(20, n);
      checks++;
      if (bus.result !== exp_sum || bus.result_id !== IW'(exp_w)) begin
        errors++;
        $display("FAIL fair_result_%0d: result=%h id=%0d, want %h/%0d", j, bus.result, bus.result_id, exp_sum, exp_w);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_width();
    logic [NR-1:0] a;
    int n;
    do_reset();
    for (int i = 0; i < LEN; i++) bus.req_data[2][i] = 32'hFFFF_FFFF;
    bus.req = 4'b0100;
    wait_ack(4, a, n);
    bus.req = '0;
    wait_valid(20, n);
    checks++;
    if (bus.result !== 35'h7_FFFF_FFF8 || bus.result_id !== 2'd2) begin
      errors++;
      $display("FAIL width_result: result=%h id=%0d, want 7fffffff8/2", bus.result, bus.result_id);
    end
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] a;
    logic [SW-1:0] exp_sum;
    int n, exp_w;
    do_reset();
    rand_vec(0);
    rand_vec(1);
    bus.result_ready = 1'b0;
    bus.req = 4'b0001;
    exp_w = rr_pick(bus.req, model_last);
    wait_ack(4, a, n);
    exp_sum = vec_sum(bus.req_data[exp_w]);
    model_last = exp_w;
    bus.req = 4'b0010;
    wait_valid(20, n);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.result_valid !== 1'b1 || bus.result !== exp_sum || bus.result_id !== IW'(exp_w) ||
          bus.busy !== 1'b1 || bus.ack !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%b result=%h id=%0d busy=%b ack=%b, want 1/%h/%0d/1/0000",
                 k, bus.result_valid, bus.result, bus.result_id, bus.busy, bus.ack, exp_sum, exp_w);
      end
      @(negedge clk);
    end
    bus.result_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b0 || bus.ack !== 4'b0000) begin
      errors++;
      $display("FAIL bp_accept: valid=%b ack=%b, want 0/0000", bus.result_valid, bus.ack);
    end
    exp_w = rr_pick(bus.req, model_last);
    exp_sum = vec_sum(bus.req_data[exp_w]);
    @(negedge clk);
    checks++;
    if (bus.ack !== onehot(exp_w)) begin
      errors++;
      $display("FAIL bp_next_ack: ack=%b, want %b", bus.ack, onehot(exp_w));
    end
    bus.req = '0;
    model_last = exp_w;
    wait_valid(20, n);
    checks++;
    if (bus.result !== exp_sum || bus.result_id !== IW'(exp_w)) begin
      errors++;
      $display("FAIL bp_second: result=%h id=%0d, want %h/%0d", bus.result, bus.result_id, exp_sum, exp_w);
    end
  endtask

  task automatic test_flush();
    logic [NR-1:0] a;
    logic [SW-1:0] exp_sum;
    int n, exp_w;
    logic seen;
    do_reset();
    rand_vec(2);
    rand_vec(3);
    bus.req = 4'b0100;
    wait_ack(4, a, n);
    model_last = rr_pick(bus.req, model_last);
    bus.req = '0;
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b valid=%b, want 0/0", bus.busy, bus.result_valid);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_result: valid seen=%b, want 0", seen);
    end
    bus.req = 4'b1000;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.ack !== 4'b0000) begin
      errors++;
      $display("FAIL flush_blocks_grant: ack=%b, want 0000", bus.ack);
    end
    exp_w = rr_pick(bus.req, model_last);
    wait_ack(4, a, n);
    exp_sum = vec_sum(bus.req_data[exp_w]);
    model_last = exp_w;
    bus.req = '0;
    wait_valid(20, n);
    checks++;
    if (a !== onehot(exp_w) || n != LEN || bus.result !== exp_sum || bus.result_id !== IW'(exp_w)) begin
      errors++;
      $display("FAIL flush_next_job: ack=%b latency=%0d result=%h, want %b/%0d/%h", a, n, bus.result, onehot(exp_w), LEN, exp_sum);
    end
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] a;
    logic [SW-1:0] exp_sum;
    int n, exp_w;
    do_reset();
    rand_vec(0);
    rand_vec(1);
    bus.req = 4'b0001;
    wait_ack(4, a, n);
    bus.req = '0;
    wait_valid(20, n);
    @(negedge clk);
    bus.req = 4'b0010;
    wait_ack(4, a, n);
    bus.req = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.result_valid !== 1'b0 ||
        bus.result !== 35'd0 || bus.result_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid: ack=%b busy=%b valid=%b result=%h id=%0d, want all 0",
               bus.ack, bus.busy, bus.result_valid, bus.result, bus.result_id);
    end
    @(negedge clk);
    rst = 1'b0;
    model_last = NR - 1;
    for (int r = 0; r < NR; r++) rand_vec(r);
    bus.req = 4'b1111;
    exp_w = rr_pick(bus.req, model_last);
    wait_ack(4, a, n);
    exp_sum = vec_sum(bus.req_data[exp_w]);
    bus.req = '0;
    wait_valid(20, n);
    checks++;
    if (a !== onehot(exp_w) || bus.result !== exp_sum || bus.result_id !== IW'(exp_w)) begin
      errors++;
      $display("FAIL rst_restart: ack=%b result=%h id=%0d, want %b/%h/%0d", a, bus.result, bus.result_id, onehot(exp_w), exp_sum, exp_w);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] a, pattern;
    logic [SW-1:0] exp_sum;
    int n, k, exp_w;
    logic rdy, accepted;
    do_reset();
    for (int it = 0; it < 25; it++) begin
      pattern = NR'($urandom_range(1, (1 << NR) - 1));
      for (int r = 0; r < NR; r++) rand_vec(r);
      bus.req = pattern;
      exp_w = rr_pick(pattern, model_last);
      wait_ack(4, a, n);
      checks++;
      if (a !== onehot(exp_w) || n != 1) begin
        errors++;
        $display("FAIL rand_ack_%0d: req=%b ack=%b after %0d, want %b after 1", it, pattern, a, n, onehot(exp_w));
      end
      exp_sum = vec_sum(bus.req_data[exp_w]);
      model_last = exp_w;
      bus.req = '0;
      rand_vec(exp_w);
      bus.result_ready = 1'($urandom_range(0, 1));
      wait_valid(20, n);
      checks++;
      if (n != LEN) begin
        errors++;
        $display("FAIL rand_latency_%0d: latency=%0d, want %0d", it, n, LEN);
      end
      accepted = 1'b0;
      k = 0;
      while (!accepted && k < 20) begin
        checks++;
        if (bus.result_valid !== 1'b1 || bus.result !== exp_sum || bus.result_id !== IW'(exp_w)) begin
          errors++;
          $display("FAIL rand_result_%0d: valid=%b result=%h id=%0d, want 1/%h/%0d", it, bus.result_valid, bus.result, bus.result_id, exp_sum, exp_w);
        end
        rdy = 1'($urandom_range(0, 1));
        bus.result_ready = rdy;
        @(negedge clk);
        k++;
        accepted = rdy;
      end
      checks++;
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_accept_%0d: valid=%b busy=%b, want 0/0", it, bus.result_valid, bus.busy);
      end
    end
  endtask

  initial begin
    bus.req = '0;
    bus.req_data = '0;
    bus.flush = 1'b0;
    bus.result_ready = 1'b1;
    model_last = NR - 1;
    test_reset();
    test_single();
    test_all_req();
    test_fairness();
    test_width();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/sum_scheduler.md
# sum_scheduler

Round-robin scheduler that shares one sequential accumulator among `NUM_REQ` requesters, each presenting a `LENGTH`-element vector to be summed. The block arbitrates between requesters and snapshots the winner's vector. It sums that vector one element per cycle and returns the tagged result over a valid/ready handshake. It sits in front of the List summation datapath, where several clients need vector sums but area allows only one adder.

## Interface
- `DATA_WIDTH`, 32, element width in bits
- `LENGTH`, 8, elements per vector; must be ≥ 2; need not be a power of 2
- `NUM_REQ`, 4, number of requesters; must be ≥ 2
- Derived: `SUM_WIDTH` = `DATA_WIDTH + $clog2(LENGTH)`; `ID_WIDTH` = `$clog2(NUM_REQ)`
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  `NUM_REQ`  level request, one bit per requester
- `req_data`  in  `[NUM_REQ-1:0][LENGTH-1:0][DATA_WIDTH-1:0]`  per-requester vector; element 0 is summed first
- `flush`  in  1  synchronous abort of the current job
- `ack`  out  `NUM_REQ`  one-cycle grant pulse to the winning requester
- `busy`  out  1  high in ACCUM and DONE
- `result`  out  `SUM_WIDTH`  unsigned sum
- `result_id`  out  `ID_WIDTH`  requester that owns `result`
- `result_valid`  out  1  result available
- `result_ready`  in  1  consumer accepts result

## Operation
- FSM has three states: IDLE, ACCUM, DONE. Reset state is IDLE.
- All outputs are registered. Reset values: `ack`=0, `busy`=0, `result`=0, `result_id`=0, `result_valid`=0.
- Internally, the round-robin pointer `last` resets to `NUM_REQ-1`, so requester 0 has top priority first.
- **IDLE, `req` nonzero, `flush`=0:**
  - Winner = first set `req` bit searching from `last+1` upward, wrapping at `NUM_REQ`.
  - Latch `req_data[winner]` into an internal buffer. Set `last`=winner, `result_id`=winner.
  - Clear the accumulator and element pointer. Pulse `ack[winner]` for one cycle. Go to ACCUM.
- **ACCUM:**
  - Each cycle: `acc += buf[ptr]`, `ptr++`. Additions are zero-extended to `SUM_WIDTH`; overflow cannot occur.
  - On the cycle that adds element `LENGTH-1`: `result` ← final sum, `result_valid` ← 1, go to DONE.
- **DONE:** `result` and `result_id` stay stable while `result_valid`=1. When `result_ready` is sampled high: `result_valid` ← 0, go to IDLE.
- **Requester protocol:**
  - A requester holds `req` until it sees `ack`.
  - `req` still high in the first IDLE cycle after `ack` counts as a new request.
  - `req_data` is sampled only at the grant edge. A requester may change it freely once `ack` is seen.
  - `req` dropped before grant is a withdrawn request; no job is run.
- **`flush`:** In ACCUM or DONE, `flush` returns the FSM to IDLE with `result_valid`=0 and no result delivered. In IDLE, `flush` suppresses granting for that cycle. `flush` has priority over all other events.
- **Reset mid-operation:** asynchronous return to reset values; any in-flight job is lost.

## Timing
- Edge E0 is the IDLE edge that samples `req`.
  - `ack` is high for the single cycle after E0.
  - Edges E1..E`LENGTH` perform the accumulations.
  - `result_valid` rises after E`LENGTH`.
  - Grant-to-result latency is `LENGTH` cycles after `ack`.
- The FSM spends at least one cycle in IDLE between jobs. With `result_ready` held high, back-to-back job period = `LENGTH+2` cycles.
- `result_ready` high at the edge where `result_valid` first rises has no effect. Acceptance happens at the following edge, when `result_valid` is observed high.
- New `req` activity during ACCUM/DONE is not granted until IDLE. Pending requests are not lost as long as `req` is held.

## Test plan
- **Single job:** `req`=0001, `req_data[0]`=1..8, `result_ready`=1.
  - `ack`=0001 for one cycle.
  - `result`=36, `result_id`=0, valid 8 cycles after `ack`.
  - `busy` falls one cycle later.
- **All requesters at once:** `req`=1111 held until each sees its own `ack`.
  - Grant order is 0,1,2,3.
  - Results are tagged `result_id` 0,1,2,3, spaced 10 cycles apart.
- **Fairness:** `req[0]` and `req[2]` held high continuously. Grants alternate 0,2,0,2; requesters 1 and 3 are never acked.
- **Width:** all elements `0xFFFFFFFF`, `LENGTH`=8 → `result`=`0x7_FFFFFFF8` (35 bits).
- **Backpressure:** `result_ready` held low for 5 cycles after valid.
  - `result`/`result_id` hold and `busy`=1.
  - No new `ack` while pending `req[1]`=1.
  - `ack[1]` arrives 2 cycles after `result_ready` rises.
- **Flush and reset:**
  - `flush` pulsed at the 3rd ACCUM cycle → no `result_valid`; FSM in IDLE next cycle; the next job sums correctly.
  - `rst` asserted mid-ACCUM → all outputs 0 immediately; after release requester 0 wins first.
